// File: rtl/payloadsmem_arbiter_if.sv
// Bus bundle between the two payload requesters, the arbiter and the
// single-port payload memory. The master side is the requester/memory
// environment; the slave side is the arbiter.
interface payloadsmem_arbiter_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 8
);
  logic              en;
  logic              req0, req1;
  logic              lock0, lock1;
  logic              we0, we1;
  logic [AWIDTH-1:0] addr0, addr1;
  logic [DWIDTH-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DWIDTH-1:0] rdata0, rdata1;
  logic              mem_ce, mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  modport slave (
    input  en, req0, req1, lock0, lock1, we0, we1, addr0, addr1,
           wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_ce, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output en, req0, req1, lock0, lock1, we0, we1, addr0, addr1,
           wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_ce, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/payloadsmem_arbiter.sv
// Two-requester arbiter in front of the single-port payload RAM.
// One access per cycle, round-robin on ties, locked bursts capped at
// MAX_BURST, and read data steered back to the requester that read.
module payloadsmem_arbiter #(
  parameter int AWIDTH    = 12,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  payloadsmem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;

  owner_t        owner_q;
  logic [CW-1:0] burst_cnt_q;
  logic          last_winner_q;
  logic [1:0]    rd_pend_q;

  logic          own_lock0, own_lock1, free_arb;
  logic          gnt0, gnt1;
  logic          win1, win_lock;
  logic [CW-1:0] cnt_inc;

  // An owner that still holds its lock excludes the other side; otherwise
  // the release is effective this very cycle and arbitration is free.
  assign own_lock0 = (owner_q == OWN0) && bus.lock0;
  assign own_lock1 = (owner_q == OWN1) && bus.lock1;
  assign free_arb  = !(own_lock0 || own_lock1);
  assign win1      = gnt1;
  assign win_lock  = gnt1 ? bus.lock1 : bus.lock0;
  assign cnt_inc   = burst_cnt_q + CW'(1);

  // Grant decision from registered state and the current requests.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && bus.en) begin
      if (own_lock0) begin
        gnt0 = bus.req0;
      end else if (own_lock1) begin
        gnt1 = bus.req1;
      end else if (bus.req0 && bus.req1) begin
        gnt0 = last_winner_q;
        gnt1 = ~last_winner_q;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  // Ownership, burst length, round-robin pointer and read-return tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q       <= OWN_NONE;
      burst_cnt_q   <= '0;
      last_winner_q <= 1'b1;
      rd_pend_q     <= 2'b00;
    end else begin
      rd_pend_q <= {gnt1 & ~bus.we1, gnt0 & ~bus.we0};
      if (!bus.en) begin
        owner_q     <= OWN_NONE;
        burst_cnt_q <= '0;
      end else if (gnt0 || gnt1) begin
        last_winner_q <= win1;
        if (!win_lock) begin
          owner_q     <= OWN_NONE;
          burst_cnt_q <= '0;
        end else if (free_arb) begin
          // Fresh burst; a cap of one means the lock can never be kept.
          if (MAX_BURST == 1) begin
            owner_q     <= OWN_NONE;
            burst_cnt_q <= '0;
          end else begin
            owner_q     <= win1 ? OWN1 : OWN0;
            burst_cnt_q <= CW'(1);
          end
        end else if (cnt_inc == CW'(MAX_BURST)) begin
          // Forced release; last_winner hands the next tie to the other side.
          owner_q     <= OWN_NONE;
          burst_cnt_q <= '0;
        end else begin
          burst_cnt_q <= cnt_inc;
        end
      end else if (free_arb) begin
        // Lock dropped with nothing granted: ownership simply lapses.
        owner_q     <= OWN_NONE;
        burst_cnt_q <= '0;
      end
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_ce    = gnt0 | gnt1;
  assign bus.mem_we    = (gnt1 & bus.we1) | (gnt0 & bus.we0);
  assign bus.mem_addr  = gnt1 ? bus.addr1  : bus.addr0;
  assign bus.mem_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
  assign bus.rvalid0   = rst_n & rd_pend_q[0];
  assign bus.rvalid1   = rst_n & rd_pend_q[1];
  assign bus.rdata0    = bus.mem_rdata;
  assign bus.rdata1    = bus.mem_rdata;
endmodule
